// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Types and constants shared by the FIFO and the blocks around it. The default
// data width and FIFO depth are here so that the arbiter and the FIFO always
// agree. The state encoding of the write arbiter is defined here as well.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int WIDTH     = 8;
  localparam int FIFO_SIZE = 16;

  // Write-arbiter states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rr_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_rr_wr_arbiter_if
// Producer handshake bundle and FIFO write-port bundle of the write arbiter.
//
//   req_valid     [NUM_REQ]        per-producer data valid
//   req_data      [NUM_REQ*WIDTH]  producer i at bits [i*WIDTH +: WIDTH]
//   req_ready     [NUM_REQ]        per-producer accept
//   fifo_full                      FIFO full flag
//   fifo_overflow                  FIFO overflow flag
//   fifo_wr_en                     FIFO write enable
//   fifo_wdata    [WIDTH]          FIFO write data
//
// Modports:
//   master : the arbiter. It drives ready and the FIFO write port.
//   slave  : the environment. It drives the producers and the FIFO flags.
// -----------------------------------------------------------------------------
interface fifo_rr_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = fifo_pkg::WIDTH
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_overflow;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wdata;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_wdata
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_wdata
  );

endinterface : fifo_rr_wr_arbiter_if

// File: rtl/fifo_rr_wr_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. The scan starts at last_owner+1 and
// wraps modulo NUM_REQ. The first set bit of valid wins, so last_owner has
// the lowest priority.
//
//   valid       [NUM_REQ]   candidate requests
//   last_owner  [ID_WIDTH]  most recent owner (lowest priority)
//   pick_onehot [NUM_REQ]   winner, one-hot (all zero when nothing is valid)
//   pick_idx    [ID_WIDTH]  winner, binary (zero when nothing is valid)
//   any_valid               at least one bit of valid is set
// -----------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [ID_WIDTH-1:0] last_owner,
  output logic [NUM_REQ-1:0]  pick_onehot,
  output logic [ID_WIDTH-1:0] pick_idx,
  output logic                any_valid
);

  int                  sum;
  logic [ID_WIDTH-1:0] idx;

  // NOTE: every variable gets a value before the scan. Without that, any path
  // that skips an assignment would infer a latch.
  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    any_valid   = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      // Wrap with a subtraction so the index never leaves 0..NUM_REQ-1,
      // even when NUM_REQ is not a power of two.
      sum = int'(last_owner) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_WIDTH'(sum);
      if (!any_valid && valid[idx]) begin
        any_valid        = 1'b1;
        pick_idx         = idx;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/fifo_rr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_wr_arbiter
// Round-robin write arbiter that shares one sync_fifo write port between
// NUM_REQ valid/ready producers. Each grant lasts for at most BURST_LEN
// writes. Every write is gated on fifo_full.
//
//   clk          clock; all logic on posedge
//   res          synchronous reset, active-low
//   bus          fifo_rr_wr_arbiter_if.master (producers + FIFO write port)
//   grant_valid  arbiter is in GRANT
//   grant_id     current owner
//   xfer_count   total accepted writes, saturates at all-ones
//   ovf_err      sticky: fifo_overflow was seen since reset
// -----------------------------------------------------------------------------
module fifo_rr_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = fifo_pkg::WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  fifo_rr_wr_arbiter_if.master     bus,
  output logic                     grant_valid,
  output logic [ID_WIDTH-1:0]      grant_id,
  output logic [CNT_WIDTH-1:0]     xfer_count,
  output logic                     ovf_err
);

  import fifo_pkg::*;

  localparam int                  BCNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [BCNT_W-1:0]   BURST_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [ID_WIDTH-1:0] LAST_RST   = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0]  OH_RST     = NUM_REQ'(1);

  state_e               state_q,      state_d;
  logic [ID_WIDTH-1:0]  owner_q,      owner_d;
  logic [NUM_REQ-1:0]   owner_oh_q,   owner_oh_d;
  logic [ID_WIDTH-1:0]  last_owner_q, last_owner_d;
  logic [BCNT_W-1:0]    burst_cnt_q,  burst_cnt_d;
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;
  logic                 ovf_err_q,    ovf_err_d;

  logic [ID_WIDTH-1:0]  pick_base;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 pick_any;

  logic                 granted;
  logic                 owner_valid;
  logic                 xfer;
  logic [WIDTH-1:0]     owner_data;

  // One picker serves both cases. In IDLE it scans from the stored
  // last_owner. In GRANT it scans from the current owner, which becomes
  // last_owner if this cycle ends the grant.
  assign pick_base = (state_q == ST_GRANT) ? owner_q : last_owner_q;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .valid       (bus.req_valid),
    .last_owner  (pick_base),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .any_valid   (pick_any)
  );

  // Ownership is also kept in one-hot form, so the ready and data muxes need
  // no decoder. Reset is folded in so that no write is issued in the cycle
  // in which a burst is aborted.
  assign granted     = (state_q == ST_GRANT) && res;
  assign owner_valid = |(bus.req_valid & owner_oh_q);
  assign xfer        = granted && owner_valid && !bus.fifo_full;

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_oh_q[i]) owner_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.req_ready  = owner_oh_q & {NUM_REQ{granted && !bus.fifo_full}};
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_wdata = xfer ? owner_data : '0;

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_id    = owner_q;
  assign xfer_count  = xfer_count_q;
  assign ovf_err     = ovf_err_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_oh_d   = owner_oh_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    xfer_count_d = xfer_count_q;
    ovf_err_d    = ovf_err_q | bus.fifo_overflow;

    unique case (state_q)
      ST_IDLE: begin
        // Arbitration bubble: only pick an owner here, never transfer.
        if (pick_any) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          owner_oh_d = pick_onehot;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (xfer_count_q != '1) xfer_count_d = xfer_count_q + 1'b1;
        end
        // While the FIFO is full, xfer is 0. The burst then cannot complete,
        // so the owner is held. Dropping valid still releases the grant.
        if (!owner_valid || (xfer && burst_cnt_q == BURST_LAST)) begin
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
          if (pick_any) begin
            owner_d    = pick_idx;
            owner_oh_d = pick_onehot;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments. Every flop then
  // samples its pre-edge value, whatever the order of the statements.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      owner_oh_q   <= OH_RST;
      last_owner_q <= LAST_RST;
      burst_cnt_q  <= '0;
      xfer_count_q <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      owner_oh_q   <= owner_oh_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      xfer_count_q <= xfer_count_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

endmodule : fifo_rr_wr_arbiter

// File: tb/tb_fifo_rr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_wr_arbiter
// Drives the arbiter from per-producer word queues. A queue-based FIFO is
// attached to the write port. Every cycle the bench predicts all outputs
// from a transaction-level model of the arbitration rules. Directed phases
// are followed by a randomized soak. CNT_WIDTH is 4 so that saturation of
// the transfer counter is reached quickly.
// -----------------------------------------------------------------------------
module tb_fifo_rr_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_WIDTH = 4;
  localparam int ID_WIDTH  = 2;
  localparam int FIFO_SIZE = 16;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  fifo_rr_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  logic                 grant_valid;
  logic [ID_WIDTH-1:0]  grant_id;
  logic [CNT_WIDTH-1:0] xfer_count;
  logic                 ovf_err;

  fifo_rr_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN),
    .CNT_WIDTH (CNT_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) dut (
    .clk         (clk),
    .res         (res),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .xfer_count  (xfer_count),
    .ovf_err     (ovf_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the arbiter, at transaction level.
  bit m_grant;
  int m_owner, m_last, m_burst, m_count;
  bit m_ovf;

  logic [WIDTH-1:0]   prod_q[NUM_REQ][$];
  logic [WIDTH-1:0]   fifo_q[$];
  logic [WIDTH-1:0]   popped[$];
  logic [NUM_REQ-1:0] v_cur;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int base);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(base + k) % NUM_REQ]) return (base + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_grant = 1'b0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
    m_burst = 0;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the outputs against the model, then
  // advance the model and the attached FIFO.
  task automatic step(input int valid_pct, input bit hold, input int pop_pct,
                      input bit rst, input bit ovf, input bit refill, input string tag);
    logic [NUM_REQ-1:0] ex_ready;
    logic               ex_wr;
    logic [WIDTH-1:0]   ex_wdata;
    logic               full;
    int                 p;
    @(posedge clk);
    #1;
    res = !rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (refill && prod_q[i].size() == 0) prod_q[i].push_back(WIDTH'($urandom));
      if (prod_q[i].size() == 0) v_cur[i] = 1'b0;
      else if (!(hold && v_cur[i])) v_cur[i] = ($urandom_range(99) < valid_pct);
      bus.req_data[i*WIDTH +: WIDTH] = (prod_q[i].size() != 0) ? prod_q[i][0]
                                                                : WIDTH'($urandom);
    end
    full              = (fifo_q.size() >= FIFO_SIZE);
    bus.req_valid     = v_cur;
    bus.fifo_full     = full;
    bus.fifo_overflow = ovf;

    @(negedge clk);
    ex_ready = '0;
    ex_wr    = 1'b0;
    ex_wdata = '0;
    if (m_grant && !rst) begin
      ex_ready[m_owner] = !full;
      ex_wr             = v_cur[m_owner] && !full;
      if (ex_wr) ex_wdata = prod_q[m_owner][0];
    end
    check({tag, ".grant_valid"}, 32'(grant_valid),    32'(m_grant));
    check({tag, ".grant_id"},    32'(grant_id),       32'(m_owner));
    check({tag, ".req_ready"},   32'(bus.req_ready),  32'(ex_ready));
    check({tag, ".wr_en"},       32'(bus.fifo_wr_en), 32'(ex_wr));
    check({tag, ".wdata"},       32'(bus.fifo_wdata), 32'(ex_wdata));
    check({tag, ".xfer_count"},  32'(xfer_count),     32'(m_count));
    check({tag, ".ovf_err"},     32'(ovf_err),        32'(m_ovf));

    // The FIFO follows what the DUT actually wrote. A read returns a word
    // that was stored before this edge.
    if (fifo_q.size() != 0 && $urandom_range(99) < pop_pct) popped.push_back(fifo_q.pop_front());
    if (bus.fifo_wr_en) fifo_q.push_back(bus.fifo_wdata);

    if (rst) begin
      model_reset();
    end else begin
      if (ovf) m_ovf = 1'b1;
      if (!m_grant) begin
        p = rr_pick(v_cur, m_last);
        if (p >= 0) begin
          m_grant = 1'b1;
          m_owner = p;
        end
      end else begin
        if (ex_wr) begin
          void'(prod_q[m_owner].pop_front());
          m_burst++;
          if (m_count < CNT_MAX) m_count++;
        end
        if (!v_cur[m_owner] || (ex_wr && m_burst == BURST_LEN)) begin
          m_last  = m_owner;
          m_burst = 0;
          p       = rr_pick(v_cur, m_owner);
          if (p >= 0) m_owner = p;
          else        m_grant = 1'b0;
        end
      end
    end
  endtask

  task automatic phase_reset();
    for (int i = 0; i < NUM_REQ; i++) prod_q[i].delete();
    v_cur = '0;
    repeat (2) step(0, 1'b0, 0, 1'b1, 1'b0, 1'b0, "reset");
    fifo_q.delete();
    popped.delete();
  endtask

  task automatic check_popped(input string tag, input logic [WIDTH-1:0] exp[$]);
    check({tag, ".count"}, 32'(popped.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < popped.size(); k++)
      check({tag, ".order"}, 32'(popped[k]), 32'(exp[k]));
  endtask

  initial begin
    logic [WIDTH-1:0] exp_q[$];

    res               = 1'b0;
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    v_cur             = '0;
    model_reset();

    // Single producer: bursts of 4/4/2, re-granted without a bubble.
    phase_reset();
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin
      prod_q[0].push_back(WIDTH'(8'h11 + k));
      exp_q.push_back(WIDTH'(8'h11 + k));
    end
    repeat (16) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "single");
    check("single.total", 32'(xfer_count), 32'd10);
    check_popped("single", exp_q);

    // All four producers valid: blocks of four per id, in order 0,1,2,3.
    phase_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) prod_q[i].push_back(WIDTH'(i * 16 + k));
    for (int n = 0; n < 32; n++)
      exp_q.push_back(WIDTH'(((n / 4) % 4) * 16 + (n / 16) * 4 + (n % 4)));
    repeat (40) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "rr");
    check_popped("rr", exp_q);

    // Backpressure: no reads until the FIFO is full, then drain it.
    phase_reset();
    exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      prod_q[2].push_back(WIDTH'(8'h40 + k));
      exp_q.push_back(WIDTH'(8'h40 + k));
    end
    repeat (24) step(100, 1'b1, 0, 1'b0, 1'b0, 1'b0, "bp_fill");
    check("bp.fifo_level", 32'(fifo_q.size()),     32'd16);
    check("bp.wr_en",      32'(bus.fifo_wr_en),    32'd0);
    check("bp.ready2",     32'(bus.req_ready[2]),  32'd0);
    check("bp.grant_id",   32'(grant_id),          32'd2);
    check("bp.ovf_err",    32'(ovf_err),           32'd0);
    repeat (24) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "bp_drain");
    check_popped("bp", exp_q);

    // Early drop: producer 1 runs dry after two words while producer 3 waits.
    phase_reset();
    exp_q.delete();
    prod_q[1].push_back(8'h51);
    prod_q[1].push_back(8'h52);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    for (int k = 0; k < 4; k++) begin
      prod_q[3].push_back(WIDTH'(8'h71 + k));
      exp_q.push_back(WIDTH'(8'h71 + k));
    end
    repeat (12) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "drop");
    check_popped("drop", exp_q);

    // Reset during the second write of producer 0's burst.
    phase_reset();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      prod_q[0].push_back(WIDTH'(8'h81 + k));
      exp_q.push_back(WIDTH'(8'h81 + k));
    end
    step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "mid");
    step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "mid");
    step(100, 1'b1, 100, 1'b1, 1'b0, 1'b0, "mid_rst");
    repeat (14) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b0, "mid");
    check_popped("mid", exp_q);

    // Counter saturation, then a single overflow pulse that must stay sticky.
    phase_reset();
    repeat (30) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b1, "sat");
    check("sat.count", 32'(xfer_count), 32'(CNT_MAX));
    step(100, 1'b1, 100, 1'b0, 1'b1, 1'b1, "ovf");
    repeat (5) step(100, 1'b1, 100, 1'b0, 1'b0, 1'b1, "ovf_hold");
    check("ovf.sticky", 32'(ovf_err), 32'd1);

    // Randomized soak with occasional resets, overflow pulses and stalls.
    phase_reset();
    for (int c = 0; c < 600; c++)
      step(60, 1'($urandom_range(1)), 50, ($urandom_range(99) < 1),
           ($urandom_range(99) < 2), 1'b1, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_rr_wr_arbiter
